mem_wb_skid: RTL and testbench
==============================

// Module: mem_wb_skid
// PURPOSE
//  Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  Sits between the data-memory stage and register-file writeback.
//  Adds three things to a plain stage register: stall absorption without a combinational ready
//  path, flush, and suppression of writes to register 0.
// PARAMETERS
//  DATA_W  32  width of memory read data and ALU result
//  REG_AW  5   register-index width (rd)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       synchronous, active-high reset
//  flush          in   1       discard all held entries
//  in_valid       in   1       upstream entry valid
//  in_ready       out  1       stage can accept; registered, equals !skid_v
//  in_mem_to_reg  in   1       select memory data for writeback
//  in_reg_write   in   1       writeback enable
//  in_data        in   DATA_W  memory read data
//  in_alu         in   DATA_W  ALU result
//  in_rd          in   REG_AW  destination register
//  out_valid      out  1       head entry valid
//  out_ready      in   1       downstream consumes head
//  out_mem_to_reg out  1       head fields (registered)
//  out_reg_write  out  1       head fields (registered)
//  out_data       out  DATA_W  head fields (registered)
//  out_alu        out  DATA_W  head fields (registered)
//  out_rd         out  REG_AW  head fields (registered)
//  wb_data        out  DATA_W  out_mem_to_reg ? out_data : out_alu (combinational from head regs)
// BEHAVIOUR
//  Reset: every output register is 0; head_v=0, skid_v=0; in_ready=1 the cycle after reset.
//  Reset and flush mid-transfer drop all in-flight entries; accept and pop in that cycle are void.
//  Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
//  Storage is two entries: head (drives out_*) and skid.
//  Per clock, when not in reset or flush:
//   - head empty or popped, skid full  : head <= skid, skid_v <= accept, skid <= input if accepted
//   - head empty or popped, skid empty : head <= input, head_v <= accept
//   - head full and not popped         : if accept, skid <= input, skid_v <= 1
//  Ordering is strict FIFO. Latency is 1 cycle in to out when empty.
//  Throughput is 1 per cycle with out_ready held high.
//  in_ready falls only when the skid is full; accept is never seen with skid full.
//  Flush: head_v=0 and skid_v=0 next cycle, in_ready=1 next cycle. reset has priority over flush.
//  Data fields are loaded regardless of valid; reg_write is stored qualified by valid.
//  x0 rule: an entry with in_rd==0 is stored with reg_write=0.
//  Register 0 is never written.
//  out_* are undefined-but-stable when out_valid=0, except out_reg_write, which is 0.
// CONFIGURATION
//  MEM_WB_FWD_EN defined: adds inputs fwd_rs_a and fwd_rs_b (REG_AW each) and outputs
//   fwd_hit_a and fwd_hit_b (1 each).
//   fwd_hit_x = out_valid & out_reg_write & (out_rd == fwd_rs_x) & (fwd_rs_x != 0).
//   Combinational; the forwarded value is wb_data.
//  MEM_WB_FWD_EN undefined: those ports are absent and no compare logic is built.
// STRUCTURE
//  Shared package cpu_pkg: DATA_W and REG_AW defaults; wb_ctrl_t {mem_to_reg, reg_write};
//   wb_entry_t {ctrl, data, alu, rd}.
//  One sub-module: wb_entry_reg. It is an enable-loaded wb_entry_t register plus valid bit,
//   with synchronous clear. It is instantiated twice, as head and as skid.
//  The control FSM (EMPTY / ONE / TWO, derived from head_v and skid_v) lives in the top module.
// TESTING
//  1 Pass-through: out_ready=1; send rd=3 alu=0x11, rd=4 data=0xAA mem_to_reg=1 back-to-back.
//    -> Out 1 cycle later, in order; wb_data = 0x11 then 0xAA; in_ready stays 1.
//  2 Stall: out_ready=0, send 3 entries.
//    -> Entries 1-2 accepted; in_ready=0 after 2nd; 3rd held upstream.
//    -> Raise out_ready: all 3 emerge in order, 1 per cycle.
//  3 Flush with 2 held entries plus in_valid=1 in the flush cycle.
//    -> Next cycle out_valid=0, in_ready=1; flushed-cycle input never appears.
//  4 x0: send rd=0 reg_write=1 alu=0x55.
//    -> out_valid=1, out_reg_write=0, out_alu=0x55.
//  5 Reset asserted with skid full.
//    -> Next cycle all outputs 0, in_ready=1. Random ready/valid run of 10k entries vs FIFO model.
//  6 MEM_WB_FWD_EN: head rd=7 reg_write=1.
//    -> fwd_rs_a=7 gives hit_a=1; fwd_rs_b=0 gives hit_b=0; out_valid=0 gives both hits 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ==========================================================================
// cpu_pkg: shared widths, writeback entry types and skid-stage state encoding
// Rev 1.0
// ==========================================================================
`default_nettype none

package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  typedef struct packed {
    wb_ctrl_t                ctrl;
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W-1:0]   alu;
    logic [DEF_REG_AW-1:0]   rd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } wb_state_t;

  // Skid is only ever occupied behind a full head, so {0,1} never occurs.
  function automatic wb_state_t wb_state(input logic head_v, input logic skid_v);
    if (skid_v)      return ST_TWO;
    else if (head_v) return ST_ONE;
    else             return ST_EMPTY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_entry_reg.sv
// ==========================================================================
// wb_entry_reg: enable-loaded entry register plus valid bit, synchronous clear
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_entry_reg
  import cpu_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic d_valid,
  input  T     d,
  output logic q_valid,
  output T     q
);

  T     data_q, data_d;
  logic valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = d;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb_skid.sv
// ==========================================================================
// mem_wb_skid: MEM/WB stage, valid/ready with 2-entry skid; MEM_WB_FWD_EN adds
// writeback forwarding hit compares.  Rev 1.0
// ==========================================================================
`default_nettype none

module mem_wb_skid
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] wb_data
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] fwd_rs_a,
  input  logic [REG_AW-1:0] fwd_rs_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b
`endif
);

  typedef struct packed {
    wb_ctrl_t          ctrl;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] rd;
  } entry_t;

  entry_t    head_q, skid_q, in_entry, head_d;
  logic      head_v, skid_v;
  logic      accept, clr;
  logic      head_load, head_sel_skid, head_vin, skid_load;
  wb_state_t state;

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign clr      = flush;
  assign state    = wb_state(head_v, skid_v);

  // reg_write is qualified by the transfer and forced low for x0 at capture time.
  always_comb begin
    in_entry                 = '0;
    in_entry.ctrl.mem_to_reg = in_mem_to_reg;
    in_entry.ctrl.reg_write  = in_reg_write & accept & (in_rd != '0);
    in_entry.data            = in_data;
    in_entry.alu             = in_alu;
    in_entry.rd              = in_rd;
  end

  always_comb begin
    head_load     = 1'b0;
    head_sel_skid = 1'b0;
    head_vin      = 1'b0;
    skid_load     = 1'b0;
    case (state)
      ST_ONE: begin
        if (out_ready) begin
          head_load = 1'b1;
          head_vin  = accept;
        end else begin
          skid_load = accept;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          head_load     = 1'b1;
          head_sel_skid = 1'b1;
          head_vin      = 1'b1;
          skid_load     = 1'b1;
        end
      end
      default: begin
        head_load = 1'b1;
        head_vin  = accept;
      end
    endcase
  end

  assign head_d = head_sel_skid ? skid_q : in_entry;

  wb_entry_reg #(.T(entry_t)) u_head (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .load    (head_load),
    .d_valid (head_vin),
    .d       (head_d),
    .q_valid (head_v),
    .q       (head_q)
  );

  wb_entry_reg #(.T(entry_t)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .load    (skid_load),
    .d_valid (accept),
    .d       (in_entry),
    .q_valid (skid_v),
    .q       (skid_q)
  );

  assign out_valid      = head_v;
  assign out_mem_to_reg = head_q.ctrl.mem_to_reg;
  assign out_reg_write  = head_q.ctrl.reg_write;
  assign out_data       = head_q.data;
  assign out_alu        = head_q.alu;
  assign out_rd         = head_q.rd;
  assign wb_data        = head_q.ctrl.mem_to_reg ? head_q.data : head_q.alu;

`ifdef MEM_WB_FWD_EN
  assign fwd_hit_a = out_valid & out_reg_write & (out_rd == fwd_rs_a) & (fwd_rs_a != '0);
  assign fwd_hit_b = out_valid & out_reg_write & (out_rd == fwd_rs_b) & (fwd_rs_b != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
// ==========================================================================
// tb_mem_wb_skid: scoreboard bench for mem_wb_skid (MEM_WB_FWD_EN optional)
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_mem_wb_skid;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_mem_to_reg, in_reg_write;
  logic [31:0] in_data, in_alu;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_mem_to_reg, out_reg_write;
  logic [31:0] out_data, out_alu, wb_data;
  logic [4:0]  out_rd;
`ifdef MEM_WB_FWD_EN
  logic [4:0]  fwd_rs_a, fwd_rs_b;
  logic        fwd_hit_a, fwd_hit_b;
`endif

  logic        exp_rw;
  logic [31:0] exp_wb;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wb;
    logic [31:0] alu;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_wb_skid dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_write   (in_reg_write),
    .in_data        (in_data),
    .in_alu         (in_alu),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mem_to_reg (out_mem_to_reg),
    .out_reg_write  (out_reg_write),
    .out_data       (out_data),
    .out_alu        (out_alu),
    .out_rd         (out_rd),
    .wb_data        (wb_data)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_rs_a       (fwd_rs_a),
    .fwd_rs_b       (fwd_rs_b),
    .fwd_hit_a      (fwd_hit_a),
    .fwd_hit_b      (fwd_hit_b)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m2r, input logic rw, input logic [31:0] data,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic erw, input logic [31:0] ewb);
    in_valid      = 1'b1;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_data       = data;
    in_alu        = alu;
    in_rd         = rd;
    exp_rw        = erw;
    exp_wb        = ewb;
  endtask

  // Stimulus side: record the expected response of every accepted entry.
  always @(negedge clk) begin
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{rd: in_rd, rw: exp_rw, wb: exp_wb, alu: in_alu});
  end

  // Monitor side: compare every popped head against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pop_rd",  64'(out_rd),        64'(e.rd));
          chk("pop_rw",  64'(out_reg_write), 64'(e.rw));
          chk("pop_wb",  64'(wb_data),       64'(e.wb));
          chk("pop_alu", 64'(out_alu),       64'(e.alu));
        end
      end
      if (!out_valid) chk("idle_reg_write", 64'(out_reg_write), 64'd0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc;
    logic acc, m2r, rw;
    logic [31:0] d, a;
    logic [4:0] rd;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b0; in_data = '0; in_alu = '0; in_rd = '0;
    exp_rw = 1'b0; exp_wb = '0;
`ifdef MEM_WB_FWD_EN
    fwd_rs_a = '0; fwd_rs_b = '0;
`endif
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_wb_data",   64'(wb_data),   64'd0);
    chk("rst_out_rd",    64'(out_rd),    64'd0);
    reset = 1'b0;
    tick();

    // Pass-through, back-to-back
    out_ready = 1'b1;
    drive(1'b0, 1'b1, 32'h0, 32'h11, 5'd3, 1'b1, 32'h11);
    tick();
    chk("pt1_valid",    64'(out_valid), 64'd1);
    chk("pt1_wb",       64'(wb_data),   64'h11);
    chk("pt1_in_ready", 64'(in_ready),  64'd1);
    drive(1'b1, 1'b1, 32'hAA, 32'h0, 5'd4, 1'b1, 32'hAA);
    tick();
    chk("pt2_rd",       64'(out_rd),    64'd4);
    chk("pt2_wb",       64'(wb_data),   64'hAA);
    chk("pt2_in_ready", 64'(in_ready),  64'd1);
    in_valid = 1'b0;
    tick();
    chk("pt_idle", 64'(out_valid), 64'd0);

    // Stall: two held, third waits upstream
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h21, 5'd5, 1'b1, 32'h21);
    tick();
    chk("st1_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 1'b1, 32'h0, 32'h22, 5'd6, 1'b1, 32'h22);
    tick();
    chk("st2_in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 1'b1, 32'h0, 32'h23, 5'd7, 1'b1, 32'h23);
    tick();
    chk("st3_in_ready", 64'(in_ready), 64'd0);
    chk("st3_head_rd",  64'(out_rd),   64'd5);
    out_ready = 1'b1;
    tick();
    chk("st_drain_rd6", 64'(out_rd),   64'd6);
    chk("st_ready_up",  64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("st_drain_rd7", 64'(out_rd),    64'd7);
    chk("st_drain_v",   64'(out_valid), 64'd1);
    tick();
    chk("st_empty", 64'(out_valid), 64'd0);

    // Flush with two held entries and a valid input in the flush cycle
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h31, 5'd8, 1'b1, 32'h31);
    tick();
    drive(1'b0, 1'b1, 32'h0, 32'h32, 5'd9, 1'b1, 32'h32);
    tick();
    flush = 1'b1;
    drive(1'b0, 1'b1, 32'h0, 32'h99, 5'd10, 1'b1, 32'h99);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid),     64'd0);
    chk("fl_in_ready",  64'(in_ready),      64'd1);
    chk("fl_reg_write", 64'(out_reg_write), 64'd0);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("fl_nothing", 64'(out_valid), 64'd0);

    // x0 suppression
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h55, 5'd0, 1'b0, 32'h55);
    tick();
    in_valid = 1'b0;
    chk("x0_valid", 64'(out_valid),     64'd1);
    chk("x0_rw",    64'(out_reg_write), 64'd0);
    chk("x0_alu",   64'(out_alu),       64'h55);
    out_ready = 1'b1;
    tick();

`ifdef MEM_WB_FWD_EN
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h77, 5'd7, 1'b1, 32'h77);
    tick();
    in_valid = 1'b0;
    fwd_rs_a = 5'd7; fwd_rs_b = 5'd0;
    #1;
    chk("fwd_hit_a", 64'(fwd_hit_a), 64'd1);
    chk("fwd_hit_b", 64'(fwd_hit_b), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("fwd_idle_a", 64'(fwd_hit_a), 64'd0);
    chk("fwd_idle_b", 64'(fwd_hit_b), 64'd0);
`endif

    // Reset with skid full
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h41, 32'h42, 5'd11, 1'b1, 32'h41);
    tick();
    drive(1'b1, 1'b1, 32'h43, 32'h44, 5'd12, 1'b1, 32'h43);
    tick();
    in_valid = 1'b0;
    chk("rs_full", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_out_valid", 64'(out_valid),      64'd0);
    chk("rs_in_ready",  64'(in_ready),       64'd1);
    chk("rs_rw",        64'(out_reg_write),  64'd0);
    chk("rs_m2r",       64'(out_mem_to_reg), 64'd0);
    chk("rs_fields",    {out_rd, out_data, out_alu} != '0 ? 64'd1 : 64'd0, 64'd0);
    chk("rs_wb",        64'(wb_data),        64'd0);

    // Random valid/ready run against the scoreboard
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 80000) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        m2r = 1'($urandom_range(1)); rw = 1'($urandom_range(1));
        d = $urandom; a = $urandom; rd = 5'($urandom_range(31));
        drive(m2r, rw, d, a, rd, rw && (rd != 5'd0), m2r ? d : a);
      end
      out_ready = ($urandom_range(9) < 7);
      acc = in_valid & in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
